// File: rtl/mux2x1_arbiter_pkg.sv
// Shared types for the two-requester round-robin arbiter: FSM state encoding
// and the reset value of the last-granted flag.
package mux2x1_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  // last = 1 at reset so requester 0 wins the first tie.
  localparam logic LAST_RESET = 1'b1;

endpackage

// File: rtl/mux2x1.sv
// Plain N-bit 2:1 multiplexer: sel = 0 passes in0, sel = 1 passes in1.
module mux2x1 #(
  parameter int N = 8
) (
  input  logic [N-1:0] in0,
  input  logic [N-1:0] in1,
  input  logic         sel,
  output logic [N-1:0] y
);

  assign y = sel ? in1 : in0;

endmodule

// File: rtl/mux2x1_arbiter.sv
// Round-robin arbiter that shares one N-bit 2:1 mux between two requesters.
// Optional grant timeout is enabled by defining MUX_ARB_TIMEOUT_EN.
module mux2x1_arbiter
  import mux2x1_arbiter_pkg::*;
#(
  parameter int N        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic         iCLK,
  input  logic         iRST,
  input  logic         iReq0,
  input  logic         iReq1,
  input  logic [N-1:0] iData0,
  input  logic [N-1:0] iData1,
  output logic         oGnt0,
  output logic         oGnt1,
  output logic         oSel,
  output logic [N-1:0] oData,
  output logic         oValid
);

  // Request/grant contract: a requester holds iReqx high for as long as it
  // wants the path; oGntx rises one edge after the request is sampled and the
  // requester's word is registered on oData (oValid = 1) one edge after that.

  arb_state_e   state;
  arb_state_e   state_nxt;
  logic         last;
  logic         hold_done;
  logic [N-1:0] mux_y;

  // Elaboration marker: MAX_HOLD below 1 leaves no legal hold window.
  if (MAX_HOLD < 1) begin : g_max_hold_invalid
  end

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt;

  assign hold_done = (hold_cnt == HOLD_LAST);
`else
  assign hold_done = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (iReq0 && iReq1) state_nxt = last ? GNT0 : GNT1;
        else if (iReq0)     state_nxt = GNT0;
        else if (iReq1)     state_nxt = GNT1;
      end
      GNT0: begin
        if (!iReq0)                 state_nxt = iReq1 ? GNT1 : IDLE;
        else if (hold_done && iReq1) state_nxt = GNT1;
      end
      GNT1: begin
        if (!iReq1)                 state_nxt = iReq0 ? GNT0 : IDLE;
        else if (hold_done && iReq0) state_nxt = GNT0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state <= IDLE;
      oGnt0 <= 1'b0;
      oGnt1 <= 1'b0;
      oSel  <= 1'b0;
      last  <= LAST_RESET;
`ifdef MUX_ARB_TIMEOUT_EN
      hold_cnt <= '0;
`endif
    end else begin
      state <= state_nxt;
      oGnt0 <= (state_nxt == GNT0);
      oGnt1 <= (state_nxt == GNT1);
      // oSel keeps its previous value while idle.
      if (state_nxt == GNT0)      oSel <= 1'b0;
      else if (state_nxt == GNT1) oSel <= 1'b1;
      if (state_nxt != state) begin
        if (state_nxt == GNT0)      last <= 1'b0;
        else if (state_nxt == GNT1) last <= 1'b1;
      end
`ifdef MUX_ARB_TIMEOUT_EN
      if (state_nxt != state || state_nxt == IDLE) hold_cnt <= '0;
      else if (!hold_done)                         hold_cnt <= hold_cnt + 1'b1;
`endif
    end
  end

  mux2x1 #(.N(N)) u_mux (
    .in0 (iData0),
    .in1 (iData1),
    .sel (oSel),
    .y   (mux_y)
  );

  // Output register: captures the owner's word every granted cycle.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oData  <= '0;
      oValid <= 1'b0;
    end else if (state != IDLE) begin
      oData  <= mux_y;
      oValid <= 1'b1;
    end else begin
      oValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux2x1_arbiter.sv
// Directed bench for mux2x1_arbiter (N=8, MAX_HOLD=4); timeout expectations
// follow MUX_ARB_TIMEOUT_EN.
module tb_mux2x1_arbiter;

  localparam int N = 8;

  logic         iCLK;
  logic         iRST;
  logic         iReq0;
  logic         iReq1;
  logic [N-1:0] iData0;
  logic [N-1:0] iData1;
  logic         oGnt0;
  logic         oGnt1;
  logic         oSel;
  logic [N-1:0] oData;
  logic         oValid;

  int vectors;
  int miscompares;
  logic [N-1:0] exp_q[$];

  mux2x1_arbiter #(.N(N), .MAX_HOLD(4)) dut (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iReq0  (iReq0),
    .iReq1  (iReq1),
    .iData0 (iData0),
    .iData1 (iData1),
    .oGnt0  (oGnt0),
    .oGnt1  (oGnt1),
    .oSel   (oSel),
    .oData  (oData),
    .oValid (oValid)
  );

  // clock / reset
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic g0, input logic g1,
                            input logic sel, input logic valid, input logic [N-1:0] data);
    check({tag, ".gnt0"},  N'(oGnt0),  N'(g0));
    check({tag, ".gnt1"},  N'(oGnt1),  N'(g1));
    check({tag, ".sel"},   N'(oSel),   N'(sel));
    check({tag, ".valid"}, N'(oValid), N'(valid));
    check({tag, ".data"},  oData,      data);
  endtask

  task automatic check_gnt(input string tag, input logic g0, input logic g1);
    check({tag, ".gnt0"}, N'(oGnt0), N'(g0));
    check({tag, ".gnt1"}, N'(oGnt1), N'(g1));
  endtask

  initial begin
    logic [N-1:0] w;
    logic [N-1:0] words [2];
    logic         rr_exp [3];
    vectors     = 0;
    miscompares = 0;
    iRST   = 1'b1;
    iReq0  = 1'b0;
    iReq1  = 1'b0;
    iData0 = '0;
    iData1 = '0;
    repeat (2) tick();
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    iRST = 1'b0;

    // reset mid-grant
    iReq0  = 1'b1;
    iData0 = 8'hA5;
    tick();
    check_outs("mid_grant0", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    check_outs("mid_grant1", 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5);
    #2 iRST = 1'b1;
    #1 check_outs("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    check_outs("rst_held", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    iRST = 1'b0;
    tick();
    check_outs("rst_rel_gnt", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    check_outs("rst_rel_data", 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5);
    iReq0 = 1'b0;
    tick();
    check_outs("drop0", 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5);
    tick();
    check_outs("idle0", 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);

    // tie after reset, then handover without a bubble
    iRST = 1'b1;
    tick();
    check_outs("tie_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    iRST   = 1'b0;
    iData0 = 8'h11;
    iData1 = 8'h22;
    iReq0  = 1'b1;
    iReq1  = 1'b1;
    tick();
    check_outs("tie_first", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    check_outs("tie_data0", 1'b1, 1'b0, 1'b0, 1'b1, 8'h11);
    iReq0 = 1'b0;
    tick();
    check_outs("handover", 1'b0, 1'b1, 1'b1, 1'b1, 8'h11);
    tick();
    check_outs("tie_data1", 1'b0, 1'b1, 1'b1, 1'b1, 8'h22);
    iReq1 = 1'b0;
    tick();
    check_outs("drop1", 1'b0, 1'b0, 1'b1, 1'b1, 8'h22);
    tick();
    check_outs("idle_sel_hold", 1'b0, 1'b0, 1'b1, 1'b0, 8'h22);

    // round robin: last = 1 here, so pulses grant 0, 1, 0
    rr_exp[0] = 1'b0;
    rr_exp[1] = 1'b1;
    rr_exp[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iReq0 = 1'b1;
      iReq1 = 1'b1;
      tick();
      check_gnt($sformatf("rr%0d", i), ~rr_exp[i], rr_exp[i]);
      iReq0 = 1'b0;
      iReq1 = 1'b0;
      tick();
      check_gnt($sformatf("rr%0d_idle", i), 1'b0, 1'b0);
    end
    tick();

    // data path through requester 1
    iReq1  = 1'b1;
    iData1 = 8'h3C;
    tick();
    check_gnt("dp_gnt", 1'b0, 1'b1);
    words[0] = 8'h3C;
    words[1] = 8'h7E;
    for (int i = 0; i < 2; i++) begin
      iData1 = words[i];
      exp_q.push_back(words[i]);
      tick();
      w = exp_q.pop_front();
      check_outs($sformatf("dp%0d", i), 1'b0, 1'b1, 1'b1, 1'b1, w);
    end
    iReq1 = 1'b0;
    repeat (2) tick();

    // contention with requester 0 holding
    iReq0 = 1'b1;
    tick();
    check_gnt("hold_enter", 1'b1, 1'b0);
    iReq1 = 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_gnt($sformatf("timeout%0d", i), (i < 4), (i == 4));
    end
`else
    for (int i = 1; i <= 20; i++) begin
      tick();
      check_gnt($sformatf("no_timeout%0d", i), 1'b1, 1'b0);
    end
    iReq0 = 1'b0;
    tick();
    check_gnt("no_timeout_drop", 1'b0, 1'b1);
`endif
    iReq0 = 1'b0;
    iReq1 = 1'b0;
    repeat (2) tick();

    // uncontended grant persists
    iReq0 = 1'b1;
    tick();
    for (int i = 0; i < 22; i++) begin
      tick();
      check_gnt($sformatf("persist%0d", i), 1'b1, 1'b0);
    end
    iReq0 = 1'b0;
    tick();
    check_gnt("final_idle", 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
